// File: rtl/uart_key_port.sv
// rtl/uart_key_port.sv - UART key-event receiver exposed as a cs/rd/wr/addr register block
module uart_key_port #(
    parameter int          CLKS_PER_BIT = 8,
    parameter logic [7:0]  KEY_SIGNAL   = 8'h70
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cs,
    input  logic       rd,
    input  logic       wr,
    input  logic [2:0] addr,
    input  logic [7:0] in_data,
    output logic [7:0] out_data,
    input  logic       rx_in,
    output logic       irq,
    output logic [2:0] irq_id
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [0:0] P_IDLE      = 1'b0;
    localparam logic [0:0] P_WAIT_CODE = 1'b1;

    // rx synchronizer
    logic          rx_meta;
    logic          rx_sync;

    // rx deserializer
    logic [1:0]    rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    rx_shift;
    logic          stop_done;
    logic          byte_valid;
    logic [7:0]    rx_byte;
    logic          frame_err_pulse;

    // protocol decoder and registers
    logic [0:0]    p_state;
    logic [7:0]    keycode;
    logic [7:0]    last_byte;
    logic          key_rdy;
    logic          overrun;
    logic          frame_err;
    logic          irq_en;
    logic          key_accessed;

    logic          key_set;
    logic          key_read_done;
    logic          ctrl_wr;
    logic          unused_bits;

    // Reads are decoded from cs/addr alone, so rd and the non-control write bits are not consumed.
    assign unused_bits = &{1'b0, rd, in_data[7:4], in_data[0]};

    assign key_set       = byte_valid && (p_state == P_WAIT_CODE);
    assign key_read_done = cs && key_accessed;
    assign ctrl_wr       = !cs && !wr && (addr == 3'd1);

    // Two-flop synchronizer; presets to idle-high so reset never looks like a start bit.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_sync <= rx_meta;
        end
    end

    // 8N1 deserializer: verify start at half-bit, then sample each bit at its centre.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_state        <= RX_IDLE;
            rx_cnt          <= '0;
            bit_idx         <= '0;
            rx_shift        <= '0;
            stop_done       <= 1'b0;
            byte_valid      <= 1'b0;
            rx_byte         <= '0;
            frame_err_pulse <= 1'b0;
        end else begin
            byte_valid      <= 1'b0;
            frame_err_pulse <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt    <= '0;
                    stop_done <= 1'b0;
                    if (!rx_sync) begin
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_M1) begin
                        rx_cnt   <= '0;
                        bit_idx  <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == FULL_M1) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (stop_done) begin
                        // A bad stop bit may leave the line low; wait for idle before hunting again.
                        if (rx_sync) begin
                            rx_state <= RX_IDLE;
                        end
                    end else if (rx_cnt == FULL_M1) begin
                        stop_done <= 1'b1;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= rx_shift;
                        end else begin
                            frame_err_pulse <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Two-byte event decoder: KEY_SIGNAL then the key code; a framing error abandons the event.
    always_ff @(posedge clock) begin
        if (!reset) begin
            p_state   <= P_IDLE;
            keycode   <= '0;
            last_byte <= '0;
        end else if (byte_valid) begin
            last_byte <= rx_byte;
            if (p_state == P_IDLE) begin
                if (rx_byte == KEY_SIGNAL) begin
                    p_state <= P_WAIT_CODE;
                end
            end else begin
                keycode <= rx_byte;
                p_state <= P_IDLE;
            end
        end else if (frame_err_pulse) begin
            p_state <= P_IDLE;
        end
    end

    // Status bits: hardware sets take priority over read-clear and W1C clears.
    always_ff @(posedge clock) begin
        if (!reset) begin
            key_rdy      <= 1'b0;
            overrun      <= 1'b0;
            frame_err    <= 1'b0;
            irq_en       <= 1'b1;
            key_accessed <= 1'b0;
        end else begin
            if (!cs && (addr == 3'd0)) begin
                key_accessed <= 1'b1;
            end else if (cs) begin
                key_accessed <= 1'b0;
            end

            if (key_set) begin
                key_rdy <= 1'b1;
            end else if (key_read_done) begin
                key_rdy <= 1'b0;
            end

            if (key_set && key_rdy) begin
                overrun <= 1'b1;
            end else if (ctrl_wr && in_data[1]) begin
                overrun <= 1'b0;
            end

            if (frame_err_pulse) begin
                frame_err <= 1'b1;
            end else if (ctrl_wr && in_data[2]) begin
                frame_err <= 1'b0;
            end

            if (ctrl_wr) begin
                irq_en <= in_data[3];
            end
        end
    end

    // Registered interrupt outputs, key-ready taking precedence over error in irq_id.
    always_ff @(posedge clock) begin
        if (!reset) begin
            irq    <= 1'b0;
            irq_id <= 3'd0;
        end else begin
            irq <= irq_en && (key_rdy || overrun || frame_err);
            if (key_rdy) begin
                irq_id <= 3'd1;
            end else if (overrun || frame_err) begin
                irq_id <= 3'd2;
            end else begin
                irq_id <= 3'd0;
            end
        end
    end

    // Combinational read mux, zero when not selected.
    always_comb begin
        out_data = 8'h00;
        if (!cs) begin
            case (addr)
                3'd0:    out_data = keycode;
                3'd1:    out_data = {4'b0000, irq_en, frame_err, overrun, key_rdy};
                3'd2:    out_data = last_byte;
                default: out_data = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_key_port.sv
// tb/tb_uart_key_port.sv - self-checking bench for uart_key_port
module tb_uart_key_port;

    localparam int CPB = 8;

    logic       clock;
    logic       reset;
    logic       cs;
    logic       rd;
    logic       wr;
    logic [2:0] addr;
    logic [7:0] in_data;
    logic [7:0] out_data;
    logic       rx_in;
    logic       irq;
    logic [2:0] irq_id;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];

    uart_key_port #(.CLKS_PER_BIT(CPB), .KEY_SIGNAL(8'h70)) dut (
        .clock    (clock),
        .reset    (reset),
        .cs       (cs),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .in_data  (in_data),
        .out_data (out_data),
        .rx_in    (rx_in),
        .irq      (irq),
        .irq_id   (irq_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [7:0] d);
        cs   = 1'b0;
        rd   = 1'b0;
        addr = a;
        #1;
        d = out_data;
        @(negedge clock);
        cs = 1'b1;
        rd = 1'b1;
        @(negedge clock);
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [7:0] v);
        cs      = 1'b0;
        wr      = 1'b0;
        addr    = a;
        in_data = v;
        @(negedge clock);
        cs = 1'b1;
        wr = 1'b1;
        @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx_in = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (CPB) @(negedge clock);
        end
        rx_in = stop_bit;
        repeat (CPB) @(negedge clock);
        rx_in = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic send_event(input logic [7:0] code);
        send_byte(8'h70, 1'b1);
        exp_q.push_back(code);
        send_byte(code, 1'b1);
    endtask

    task automatic wait_key(input string name);
        int n;
        n = 0;
        while (irq_id !== 3'd1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (irq_id !== 3'd1) begin
            failures++;
            $display("FAIL %s_timeout irq_id=%0d required=1", name, irq_id);
        end
    endtask

    task automatic check_keycode(input string name);
        logic [7:0] d;
        logic [7:0] e;
        read_reg(3'd0, d);
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s_empty_scoreboard keycode=%h", name, d);
        end else begin
            e = exp_q.pop_front();
            if (d !== e) begin
                failures++;
                $display("FAIL %s_keycode got=%h required=%h", name, d, e);
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset = 1'b0;
        rx_in = 1'b1;
        repeat (16) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        read_reg(3'd0, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_keycode got=%h required=%h", d, 8'h00); end
        read_reg(3'd1, d);
        checks++; if (d !== 8'h08) begin failures++; $display("FAIL reset_ctrl1 got=%h required=%h", d, 8'h08); end
        read_reg(3'd2, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_last_byte got=%h required=%h", d, 8'h00); end
        checks++; if (irq !== 1'b0 || irq_id !== 3'd0) begin failures++; $display("FAIL reset_irq got=%b/%0d required=0/0", irq, irq_id); end
    endtask

    task automatic test_key_event();
        logic [7:0] d;
        send_event(8'h42);
        wait_key("key_event");
        checks++; if (irq !== 1'b1 || irq_id !== 3'd1) begin failures++; $display("FAIL key_irq got=%b/%0d required=1/1", irq, irq_id); end
        read_reg(3'd1, d);
        checks++; if (d !== 8'h09) begin failures++; $display("FAIL key_ctrl1 got=%h required=%h", d, 8'h09); end
        read_reg(3'd2, d);
        checks++; if (d !== 8'h42) begin failures++; $display("FAIL key_last_byte got=%h required=%h", d, 8'h42); end
        check_keycode("key_event");
        read_reg(3'd1, d);
        checks++; if (d !== 8'h08) begin failures++; $display("FAIL key_clear_ctrl1 got=%h required=%h", d, 8'h08); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL key_clear_irq got=%b required=0", irq); end
    endtask

    task automatic test_stray_signal();
        logic [7:0] d;
        send_byte(8'h41, 1'b1);
        tick(2);
        read_reg(3'd1, d);
        checks++; if (d !== 8'h08) begin failures++; $display("FAIL stray_ctrl1 got=%h required=%h", d, 8'h08); end
        read_reg(3'd2, d);
        checks++; if (d !== 8'h41) begin failures++; $display("FAIL stray_last_byte got=%h required=%h", d, 8'h41); end
        send_event(8'h70);
        wait_key("repeat_signal");
        read_reg(3'd1, d);
        checks++; if (d !== 8'h09) begin failures++; $display("FAIL repeat_ctrl1 got=%h required=%h", d, 8'h09); end
        check_keycode("repeat_signal");
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        logic [7:0] stale;
        send_event(8'h31);
        send_event(8'h32);
        wait_key("overrun");
        read_reg(3'd1, d);
        checks++; if (d !== 8'h0B) begin failures++; $display("FAIL overrun_ctrl1 got=%h required=%h", d, 8'h0B); end
        checks++; if (irq_id !== 3'd1) begin failures++; $display("FAIL overrun_irq_id got=%0d required=1", irq_id); end
        write_reg(3'd1, 8'h0A);
        read_reg(3'd1, d);
        checks++; if (d !== 8'h09) begin failures++; $display("FAIL overrun_w1c_ctrl1 got=%h required=%h", d, 8'h09); end
        stale = exp_q.pop_front();
        check_keycode("overrun");
    endtask

    task automatic test_frame_error();
        logic [7:0] d;
        send_byte(8'h70, 1'b0);
        tick(2);
        read_reg(3'd1, d);
        checks++; if (d !== 8'h0C) begin failures++; $display("FAIL ferr_ctrl1 got=%h required=%h", d, 8'h0C); end
        checks++; if (irq !== 1'b1 || irq_id !== 3'd2) begin failures++; $display("FAIL ferr_irq got=%b/%0d required=1/2", irq, irq_id); end
        read_reg(3'd2, d);
        checks++; if (d !== 8'h32) begin failures++; $display("FAIL ferr_dropped_last_byte got=%h required=%h", d, 8'h32); end
        send_byte(8'h42, 1'b1);
        tick(2);
        read_reg(3'd1, d);
        checks++; if (d !== 8'h0C) begin failures++; $display("FAIL ferr_pidle_ctrl1 got=%h required=%h", d, 8'h0C); end
        read_reg(3'd2, d);
        checks++; if (d !== 8'h42) begin failures++; $display("FAIL ferr_next_last_byte got=%h required=%h", d, 8'h42); end
        rx_in = 1'b0;
        tick(2);
        rx_in = 1'b1;
        tick(3 * CPB);
        read_reg(3'd2, d);
        checks++; if (d !== 8'h42) begin failures++; $display("FAIL glitch_last_byte got=%h required=%h", d, 8'h42); end
        read_reg(3'd1, d);
        checks++; if (d !== 8'h0C) begin failures++; $display("FAIL glitch_ctrl1 got=%h required=%h", d, 8'h0C); end
        write_reg(3'd1, 8'h00);
        tick(1);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_disable got=%b required=0", irq); end
        read_reg(3'd1, d);
        checks++; if (d !== 8'h04) begin failures++; $display("FAIL irq_disable_ctrl1 got=%h required=%h", d, 8'h04); end
        write_reg(3'd1, 8'h0C);
        read_reg(3'd1, d);
        checks++; if (d !== 8'h08) begin failures++; $display("FAIL ferr_w1c_ctrl1 got=%h required=%h", d, 8'h08); end
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] d;
        logic [7:0] b;
        b = 8'h42;
        send_byte(8'h70, 1'b1);
        rx_in = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            rx_in = b[i];
            repeat (CPB) @(negedge clock);
        end
        rx_in = b[3];
        repeat (CPB / 2) @(negedge clock);
        reset = 1'b0;
        rx_in = 1'b1;
        tick(4);
        reset = 1'b1;
        tick(2 * CPB);
        read_reg(3'd0, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL midrst_keycode got=%h required=%h", d, 8'h00); end
        read_reg(3'd1, d);
        checks++; if (d !== 8'h08) begin failures++; $display("FAIL midrst_ctrl1 got=%h required=%h", d, 8'h08); end
        read_reg(3'd2, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL midrst_last_byte got=%h required=%h", d, 8'h00); end
        checks++; if (irq !== 1'b0 || irq_id !== 3'd0) begin failures++; $display("FAIL midrst_irq got=%b/%0d required=0/0", irq, irq_id); end
        send_event(8'h55);
        wait_key("after_reset");
        check_keycode("after_reset");
    endtask

    initial begin
        reset   = 1'b0;
        cs      = 1'b1;
        rd      = 1'b1;
        wr      = 1'b1;
        addr    = 3'd0;
        in_data = 8'h00;
        rx_in   = 1'b1;
        @(negedge clock);
        test_reset();
        test_key_event();
        test_stray_signal();
        test_overrun();
        test_frame_error();
        test_reset_mid_byte();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
